// File: rtl/farrow_frac_delay.sv
// farrow_frac_delay
//   Multichannel, multibeam cubic Farrow fractional-delay filter. Input is a
//   time-multiplexed stream of N_CH signed channel samples. Every accepted
//   sample produces N_BEAM outputs in parallel. Each output is the same
//   channel's signal delayed by (1 + mu) samples, where mu comes from that
//   beam's entry in a loadable delay table.
//
//   Build option:
//     FARROW_SAT_EN  defined   -> outputs saturate to the signed WOUT range
//                    undefined -> outputs wrap (keep the low WOUT bits)
//
// Ports:
//   clk       sole clock
//   rst       asynchronous active-high reset
//   vld_in    input sample valid (always accepted)
//   last_in   marks the last channel of a frame
//   data_in   signed channel sample, WIN bits
//   vld_del   delay word valid
//   last_del  marks the final delay word (write pointer restarts at 0)
//   data_del  delay word m, mu = m / 2^WD
//   vld_out   output valid, 6 cycles after the matching vld_in
//   last_out  last_in carried along with its sample
//   data_out  beam j at [j*WOUT +: WOUT]; holds while vld_out is low
module farrow_frac_delay #(
  parameter int WIN    = 16,
  parameter int WOUT   = 16,
  parameter int WD     = 16,
  parameter int N_CH   = 4,
  parameter int N_BEAM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_in,
  input  logic                     last_in,
  input  logic [WIN-1:0]           data_in,
  input  logic                     vld_del,
  input  logic                     last_del,
  input  logic [WD-1:0]            data_del,
  output logic                     vld_out,
  output logic                     last_out,
  output logic [N_BEAM*WOUT-1:0]   data_out
);

  // Coefficient width (x6 scaled integer Farrow coefficients) and Horner
  // accumulator width. Neither can overflow for full-scale WIN inputs.
  localparam int CW  = WIN + 4;
  localparam int AW  = WIN + 6;
  // Horner product: signed accumulator times unsigned fraction (one extra
  // bit to keep the fraction positive when treated as signed).
  localparam int PW  = AW + WD + 1;
  // Divide-by-6 product width: accumulator times the 17-bit signed 21845.
  localparam int PPW = AW + 17;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BW  = (N_BEAM > 1) ? $clog2(N_BEAM) : 1;

  localparam logic signed [16:0]    KDIV6 = 17'sd21845;
  localparam logic signed [PPW-1:0] RND   = PPW'(65536);

`ifdef FARROW_SAT_EN
  localparam int YW = PPW - 17;
  localparam logic signed [YW-1:0] YMAX = YW'((2 ** (WOUT - 1)) - 1);
  localparam logic signed [YW-1:0] YMIN = YW'(-(2 ** (WOUT - 1)));
`endif

  // One Horner step: base + floor((a * m) / 2^WD).
  function automatic logic signed [AW-1:0] horner(
    input logic signed [AW-1:0] base,
    input logic signed [AW-1:0] a,
    input logic [WD-1:0]        m
  );
    logic signed [PW-1:0] prod;
    prod   = PW'(a) * PW'($signed({1'b0, m}));
    horner = base + AW'(prod >>> WD);
  endfunction

  // Divide by 6 with half-up rounding, then limit to WOUT bits.
  function automatic logic [WOUT-1:0] round_limit(input logic signed [PPW-1:0] p);
    logic signed [PPW-1:0] s;
`ifdef FARROW_SAT_EN
    logic signed [YW-1:0] y;
`endif
    s = p + RND;
`ifdef FARROW_SAT_EN
    y = YW'(s >>> 17);
    if (y > YMAX) begin
      round_limit = YMAX[WOUT-1:0];
    end else if (y < YMIN) begin
      round_limit = YMIN[WOUT-1:0];
    end else begin
      round_limit = y[WOUT-1:0];
    end
`else
    round_limit = WOUT'(s >>> 17);
`endif
  endfunction

  // Delay table, write pointer (kept as beam/channel pair) and channel counter
  logic [WD-1:0]          dly [N_BEAM][N_CH];
  logic [BW-1:0]          wr_beam;
  logic [CHW-1:0]         wr_ch;
  logic [CHW-1:0]         ch_cnt;

  // Per-channel sample history: [0] newest, [2] oldest
  logic signed [WIN-1:0]  hist [N_CH][3];

  // Taps and next-stage coefficients
  logic signed [CW-1:0]   x0, x1, x2, x3;
  logic signed [CW-1:0]   c0_n, c1_n, c2_n, c3_n;
  logic [WD-1:0]          m_lk [N_BEAM];

  // Pipeline registers
  logic [5:0]             v_s;
  logic [5:0]             l_s;
  logic signed [CW-1:0]   c0_s1, c1_s1, c2_s1, c3_s1;
  logic signed [CW-1:0]   c0_s2, c1_s2, c0_s3;
  logic [WD-1:0]          m_s1 [N_BEAM];
  logic [WD-1:0]          m_s2 [N_BEAM];
  logic [WD-1:0]          m_s3 [N_BEAM];
  logic signed [AW-1:0]   a2_s2 [N_BEAM];
  logic signed [AW-1:0]   a1_s3 [N_BEAM];
  logic signed [AW-1:0]   a0_s4 [N_BEAM];
  logic signed [PPW-1:0]  p_s5 [N_BEAM];

  // Delay table writes. Word k lands in beam k/N_CH, channel k%N_CH, which is
  // exactly a nested channel-then-beam counter. last_del restarts it at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_beam <= '0;
      wr_ch   <= '0;
      for (int j = 0; j < N_BEAM; j++) begin
        for (int c = 0; c < N_CH; c++) begin
          dly[j][c] <= '0;
        end
      end
    end else if (vld_del) begin
      dly[wr_beam][wr_ch] <= data_del;
      if (last_del) begin
        wr_beam <= '0;
        wr_ch   <= '0;
      end else if (wr_ch == CHW'(N_CH - 1)) begin
        wr_ch   <= '0;
        wr_beam <= (wr_beam == BW'(N_BEAM - 1)) ? '0 : wr_beam + BW'(1);
      end else begin
        wr_ch <= wr_ch + CHW'(1);
      end
    end
  end

  // Channel counter and history. A last_in sample forces the next sample to
  // be channel 0 even when the frame was short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt <= '0;
      for (int c = 0; c < N_CH; c++) begin
        for (int k = 0; k < 3; k++) begin
          hist[c][k] <= '0;
        end
      end
    end else if (vld_in) begin
      ch_cnt <= (last_in || ch_cnt == CHW'(N_CH - 1)) ? '0 : ch_cnt + CHW'(1);
      hist[ch_cnt][0] <= $signed(data_in);
      hist[ch_cnt][1] <= hist[ch_cnt][0];
      hist[ch_cnt][2] <= hist[ch_cnt][1];
    end
  end

  // Taps for the current channel and the x6 Farrow coefficients. The
  // constant multiples are built from shifts and adds at width CW.
  always_comb begin
    x0 = CW'($signed(data_in));
    x1 = CW'(hist[ch_cnt][0]);
    x2 = CW'(hist[ch_cnt][1]);
    x3 = CW'(hist[ch_cnt][2]);
    c0_n = (x1 <<< 2) + (x1 <<< 1);
    c1_n = -(x0 <<< 1) - ((x1 <<< 1) + x1) + ((x2 <<< 2) + (x2 <<< 1)) - x3;
    c2_n = ((x0 <<< 1) + x0) - ((x1 <<< 2) + (x1 <<< 1)) + ((x2 <<< 1) + x2);
    c3_n = -x0 + ((x1 <<< 1) + x1) - ((x2 <<< 1) + x2) + x3;
  end

  // Delay lookup for every beam. This reads the registered table, so a write
  // landing on the same edge is only seen by the following sample.
  always_comb begin
    for (int j = 0; j < N_BEAM; j++) begin
      m_lk[j] = dly[j][ch_cnt];
    end
  end

  // Valid and last travel alongside the data through all six stages.
  // Clearing them on reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_s <= '0;
      l_s <= '0;
    end else begin
      v_s <= {v_s[4:0], vld_in};
      l_s <= {l_s[4:0], vld_in & last_in};
    end
  end

  assign vld_out  = v_s[5];
  assign last_out = l_s[5];

  // Datapath stages 1-5: coefficients, three Horner steps, then the
  // multiply by 21845 that prepares the divide-by-6. Coefficients not yet
  // consumed and each beam's delay word ride along to the step that needs them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c0_s1 <= '0;
      c1_s1 <= '0;
      c2_s1 <= '0;
      c3_s1 <= '0;
      c0_s2 <= '0;
      c1_s2 <= '0;
      c0_s3 <= '0;
      for (int j = 0; j < N_BEAM; j++) begin
        m_s1[j]  <= '0;
        m_s2[j]  <= '0;
        m_s3[j]  <= '0;
        a2_s2[j] <= '0;
        a1_s3[j] <= '0;
        a0_s4[j] <= '0;
        p_s5[j]  <= '0;
      end
    end else begin
      c0_s1 <= c0_n;
      c1_s1 <= c1_n;
      c2_s1 <= c2_n;
      c3_s1 <= c3_n;
      c0_s2 <= c0_s1;
      c1_s2 <= c1_s1;
      c0_s3 <= c0_s2;
      for (int j = 0; j < N_BEAM; j++) begin
        m_s1[j]  <= m_lk[j];
        m_s2[j]  <= m_s1[j];
        m_s3[j]  <= m_s2[j];
        a2_s2[j] <= horner(AW'(c2_s1), AW'(c3_s1), m_s1[j]);
        a1_s3[j] <= horner(AW'(c1_s2), a2_s2[j], m_s2[j]);
        a0_s4[j] <= horner(AW'(c0_s3), a1_s3[j], m_s3[j]);
        p_s5[j]  <= PPW'(a0_s4[j]) * PPW'(KDIV6);
      end
    end
  end

  // Stage 6: round, limit and register the beam outputs. Only valid samples
  // update the register, so data_out holds between valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (v_s[4]) begin
      for (int j = 0; j < N_BEAM; j++) begin
        data_out[j*WOUT +: WOUT] <= round_limit(p_s5[j]);
      end
    end
  end

endmodule

// File: tb/tb_farrow_frac_delay.sv
// tb_farrow_frac_delay
//   Drives farrow_frac_delay with directed and random traffic and compares
//   every output against a sample-level reference model of the filter.
//   Honors FARROW_SAT_EN the same way the design does.
module tb_farrow_frac_delay;

  logic        clk;
  logic        rst;
  logic        vld_in;
  logic        last_in;
  logic [15:0] data_in;
  logic        vld_del;
  logic        last_del;
  logic [15:0] data_del;
  logic        vld_out;
  logic        last_out;
  logic [31:0] data_out;

  farrow_frac_delay #(
    .WIN(16), .WOUT(16), .WD(16), .N_CH(4), .N_BEAM(2)
  ) dut (
    .clk(clk), .rst(rst),
    .vld_in(vld_in), .last_in(last_in), .data_in(data_in),
    .vld_del(vld_del), .last_del(last_del), .data_del(data_del),
    .vld_out(vld_out), .last_out(last_out), .data_out(data_out)
  );

  // Clock and free-running cycle count used for latency measurement
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    int          cyc;
    bit          last;
    logic [31:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [31:0] heldExp;

  // Reference model state: history per channel, channel pointer, delay table
  int mHist [4][3];
  int mCh;
  int mDly  [2][4];
  int mWb;
  int mWc;

  task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Fractional-delay output from the spec's integer Farrow arithmetic
  function automatic logic [15:0] modelY(input int x0, input int x1, input int x2, input int x3, input int m);
    longint c0, c1, c2, c3, a2, a1, a0, y;
    c0 = 6 * longint'(x1);
    c1 = -2 * longint'(x0) - 3 * longint'(x1) + 6 * longint'(x2) - longint'(x3);
    c2 = 3 * longint'(x0) - 6 * longint'(x1) + 3 * longint'(x2);
    c3 = -longint'(x0) + 3 * longint'(x1) - 3 * longint'(x2) + longint'(x3);
    a2 = c2 + ((c3 * m) >>> 16);
    a1 = c1 + ((a2 * m) >>> 16);
    a0 = c0 + ((a1 * m) >>> 16);
    y  = (a0 * 21845 + 65536) >>> 17;
`ifdef FARROW_SAT_EN
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
`endif
    return y[15:0];
  endfunction

  task automatic resetModel();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 3; k++) mHist[c][k] = 0;
      for (int j = 0; j < 2; j++) mDly[j][c] = 0;
    end
    mCh = 0;
    mWb = 0;
    mWc = 0;
    sbq.delete();
    heldExp = '0;
  endtask

  // Drive one cycle of inputs, update the model and queue the expectation.
  // When ov is set the caller supplies the expected beams directly.
  task automatic applyStimulus(input bit v, input bit l, input int d, input bit vd, input bit ld, input int dd,
                               input bit ov, input logic [31:0] ovExp);
    logic [31:0] exp;
    @(negedge clk);
    vld_in   = v;
    last_in  = l;
    data_in  = d[15:0];
    vld_del  = vd;
    last_del = ld;
    data_del = dd[15:0];
    if (v) begin
      for (int j = 0; j < 2; j++) begin
        exp[j*16 +: 16] = modelY(d, mHist[mCh][0], mHist[mCh][1], mHist[mCh][2], mDly[j][mCh]);
      end
      if (ov) exp = ovExp;
      sbq.push_back('{cyc, l, exp});
      mHist[mCh][2] = mHist[mCh][1];
      mHist[mCh][1] = mHist[mCh][0];
      mHist[mCh][0] = d;
      mCh = (l || mCh == 3) ? 0 : mCh + 1;
    end
    if (vd) begin
      mDly[mWb][mWc] = dd;
      if (ld) begin
        mWb = 0;
        mWc = 0;
      end else if (mWc == 3) begin
        mWc = 0;
        mWb = (mWb + 1) % 2;
      end else begin
        mWc++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic loadDelays(input int b0, input int b1);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, k == 7, (k < 4) ? b0 : b1, 0, '0);
  endtask

  // Output monitor: one sample after each rising edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (vld_out) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_vld_out", vld_out, 0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          checkOutput("latency", cyc - e.cyc, 6);
          checkOutput("last_out", last_out, e.last);
          checkOutput("beam0", $signed(data_out[15:0]), $signed(e.exp[15:0]));
          checkOutput("beam1", $signed(data_out[31:16]), $signed(e.exp[31:16]));
          heldExp = e.exp;
        end
      end else begin
        checkOutput("hold_data_out", data_out, heldExp);
        if (sbq.size() > 0 && cyc - sbq[0].cyc > 6) begin
          checkOutput("missing_vld_out", cyc - sbq[0].cyc, 6);
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0 [4];
    int b1 [4];
    int d;
    b0 = '{0, 6000, 0, 0};
    b1 = '{-375, 3375, 3375, -375};

    rst = 1'b1;
    vld_in = 0; last_in = 0; data_in = 0;
    vld_del = 0; last_del = 0; data_del = 0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_vld_out", vld_out, 0);
    checkOutput("reset_last_out", last_out, 0);
    checkOutput("reset_data_out", data_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp with all delays zero: each beam is the previous sample
    $display("[TB] ramp, zero delay");
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 4; c++) begin
        int prev;
        prev = (n == 0) ? 0 : 100 * c + n - 1;
        applyStimulus(1, c == 3, 100 * c + n, 0, 0, 0, 1, {16'(prev), 16'(prev)});
      end
    end
    idle(8);

    // Half-sample delay on a constant input settles to the constant
    $display("[TB] constant input, mu = 0.5");
    loadDelays(32'h8000, 32'h8000);
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 4; c++) applyStimulus(1, c == 3, 1000, 0, 0, 0, n >= 3, {16'd1000, 16'd1000});
    end
    idle(8);

    // Impulse on channel 0, beam0 integer delay, beam1 half-sample delay
    $display("[TB] impulse, per-beam delays");
    loadDelays(0, 32'h8000);
    for (int n = 0; n < 3; n++) begin
      for (int c = 0; c < 4; c++) applyStimulus(1, c == 3, 0, 0, 0, 0, 0, '0);
    end
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1, c == 3, (c == 0 && n == 0) ? 6000 : 0, 0, 0, 0, c == 0, {16'(b1[n]), 16'(b0[n])});
      end
    end
    idle(8);

    // Delay reload mid-stream with an early last_del, writes coincident with samples
    $display("[TB] delay reload mid-stream");
    for (int i = 0; i < 12; i++) begin
      d = int'($urandom_range(0, 65535)) - 32768;
      applyStimulus(1, (i % 4) == 3, d, 1, i == 2, int'($urandom_range(0, 65535)), 0, '0);
    end
    idle(8);

    // Random traffic: gaps, short frames, random delay writes
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      bit v, l, vd, ld;
      v  = ($urandom_range(0, 99) < 70);
      l  = v && ($urandom_range(0, 99) < 10);
      vd = ($urandom_range(0, 99) < 15);
      ld = vd && ($urandom_range(0, 99) < 20);
      d  = int'($urandom_range(0, 65535)) - 32768;
      applyStimulus(v, l, d, vd, ld, int'($urandom_range(0, 65535)), 0, '0);
    end
    idle(8);

    // Full-scale inputs: alternating with mu = 0.5, then random extremes
    $display("[TB] full-scale inputs");
    loadDelays(32'h8000, 32'h8000);
    for (int i = 0; i < 32; i++) applyStimulus(1, (i % 4) == 3, ((i / 4) % 2) ? -32767 : 32767, 0, 0, 0, 0, '0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 1, k == 7, int'($urandom_range(16'h2000, 16'he000)), 0, '0);
    for (int i = 0; i < 96; i++) begin
      case ($urandom_range(0, 2))
        0: d = 32767;
        1: d = -32767;
        default: d = -32768;
      endcase
      applyStimulus(1, (i % 4) == 3, d, 0, 0, 0, 0, '0);
    end

    // Reset in the middle of traffic
    $display("[TB] reset during traffic");
    for (int i = 0; i < 5; i++) applyStimulus(1, (i % 4) == 3, int'($urandom_range(0, 65535)) - 32768, 0, 0, 0, 0, '0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_vld_out", vld_out, 0);
    checkOutput("midreset_last_out", last_out, 0);
    checkOutput("midreset_data_out", data_out, 0);
    resetModel();
    @(negedge clk);
    vld_in = 0; last_in = 0; vld_del = 0; last_del = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, 65535)) - 32768;
      applyStimulus(1, (i % 4) == 3, d, 0, 0, 0, 0, '0);
    end

    idle(12);
    checkOutput("drain_pending", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
